// File: rtl/arbitro_memoria_datos.sv
// Arbiter/sequencer in front of the data memory. Port 0 is the CPU load/store
// stage and port 1 is the debug/dump port. The block accepts one request at a
// time, rejects illegal addresses and drives the memory strobes for one write
// cycle or for RD_LAT read cycles. Read data comes back as a one-cycle rvalid pulse.
//
//   state | meaning
//   IDLE  | waiting for a request; the winner's fields are latched on leaving
//   ISSUE | gnt pulse; err, the write strobe or the first read cycle
//   RWAIT | read strobe held until RD_LAT cycles have elapsed
//   RESP  | rvalid pulse on the selected port
module arbitro_memoria_datos #(
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] ADDR_MAX  = 32'd1020,
    parameter bit          PRIO_FIJA = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_byte,
    input  logic [31:0] m0_ad,
    input  logic [31:0] m0_di,
    output logic        m0_gnt,
    output logic        m0_err,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_byte,
    input  logic [31:0] m1_ad,
    input  logic [31:0] m1_di,
    output logic        m1_gnt,
    output logic        m1_err,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_ad,
    output logic [31:0] mem_di,
    output logic        mem_we,
    output logic        mem_re,
    output logic        mem_byte_l,
    output logic        mem_byte_s,
    input  logic [31:0] mem_do
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        sel;
    logic        last;
    logic        op_we;
    logic        op_byte;
    logic [31:0] op_ad;
    logic [31:0] op_di;
    logic [1:0]  cnt;
    logic        winner;
    logic        illegal;
    logic        capture;
    logic        gnt_any;
    logic        err_any;
    logic        rvalid_any;

    // Pick the winning port: a lone request wins; on a tie, fixed or round-robin.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = PRIO_FIJA ? 1'b0 : ~last;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    assign illegal = (op_ad > ADDR_MAX) || (!op_byte && (op_ad[1:0] != 2'b00));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt  = state;
        gnt_any    = 1'b0;
        err_any    = 1'b0;
        rvalid_any = 1'b0;
        capture    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_byte_s = 1'b0;
        mem_byte_l = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt_any = 1'b1;
                if (illegal) begin
                    err_any   = 1'b1;
                    state_nxt = IDLE;
                end else if (op_we) begin
                    mem_we     = 1'b1;
                    mem_byte_s = op_byte;
                    state_nxt  = IDLE;
                end else begin
                    mem_re     = 1'b1;
                    mem_byte_l = op_byte;
                    if (RD_LAT == 1) begin
                        capture   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RWAIT;
                    end
                end
            end
            RWAIT: begin
                mem_re     = 1'b1;
                mem_byte_l = op_byte;
                if (cnt == 2'(RD_LAT - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rvalid_any = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m0_gnt    = gnt_any & ~sel;
    assign m1_gnt    = gnt_any & sel;
    assign m0_err    = err_any & ~sel;
    assign m1_err    = err_any & sel;
    assign m0_rvalid = rvalid_any & ~sel;
    assign m1_rvalid = rvalid_any & sel;
    assign mem_ad    = op_ad;
    assign mem_di    = op_di;

    // Latch the winner's request fields and remember it for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 1'b0;
            last    <= 1'b1;
            op_we   <= 1'b0;
            op_byte <= 1'b0;
            op_ad   <= 32'h0;
            op_di   <= 32'h0;
        end else if (state == IDLE && (m0_req || m1_req)) begin
            sel     <= winner;
            last    <= winner;
            op_we   <= winner ? m1_we   : m0_we;
            op_byte <= winner ? m1_byte : m0_byte;
            op_ad   <= winner ? m1_ad   : m0_ad;
            op_di   <= winner ? m1_di   : m0_di;
        end
    end

    // Read-latency counter: starts at 1 in ISSUE, counts up through RWAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (state == ISSUE) begin
            cnt <= 2'd1;
        end else if (state == RWAIT) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Capture read data on the last read cycle; each port keeps its last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
        end else if (capture) begin
            if (sel) begin
                m1_rdata <= mem_do;
            end else begin
                m0_rdata <= mem_do;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos. Three instances share the clock:
// [0] RD_LAT=1 round-robin, [1] RD_LAT=1 fixed priority, [2] RD_LAT=3 round-robin.
// Each instance has its own small word memory behind it.
module tb_arbitro_memoria_datos;

    logic        clk;
    logic        rst_n      [3];
    logic        req0       [3];
    logic        we0        [3];
    logic        byte0      [3];
    logic [31:0] ad0        [3];
    logic [31:0] di0        [3];
    logic        gnt0       [3];
    logic        err0       [3];
    logic        rv0        [3];
    logic [31:0] rdata0     [3];
    logic        req1       [3];
    logic        we1        [3];
    logic        byte1      [3];
    logic [31:0] ad1        [3];
    logic [31:0] di1        [3];
    logic        gnt1       [3];
    logic        err1       [3];
    logic        rv1        [3];
    logic [31:0] rdata1     [3];
    logic [31:0] mem_ad     [3];
    logic [31:0] mem_di     [3];
    logic        mem_we     [3];
    logic        mem_re     [3];
    logic        mem_byte_l [3];
    logic        mem_byte_s [3];
    logic [31:0] mem_do     [3];
    logic [31:0] mem        [3][256];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        arbitro_memoria_datos #(
            .RD_LAT    ((g == 2) ? 3 : 1),
            .ADDR_MAX  (32'd1020),
            .PRIO_FIJA ((g == 1) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .m0_req     (req0[g]),
            .m0_we      (we0[g]),
            .m0_byte    (byte0[g]),
            .m0_ad      (ad0[g]),
            .m0_di      (di0[g]),
            .m0_gnt     (gnt0[g]),
            .m0_err     (err0[g]),
            .m0_rvalid  (rv0[g]),
            .m0_rdata   (rdata0[g]),
            .m1_req     (req1[g]),
            .m1_we      (we1[g]),
            .m1_byte    (byte1[g]),
            .m1_ad      (ad1[g]),
            .m1_di      (di1[g]),
            .m1_gnt     (gnt1[g]),
            .m1_err     (err1[g]),
            .m1_rvalid  (rv1[g]),
            .m1_rdata   (rdata1[g]),
            .mem_ad     (mem_ad[g]),
            .mem_di     (mem_di[g]),
            .mem_we     (mem_we[g]),
            .mem_re     (mem_re[g]),
            .mem_byte_l (mem_byte_l[g]),
            .mem_byte_s (mem_byte_s[g]),
            .mem_do     (mem_do[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: word array, byte write merges into the addressed lane.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_we[k]) begin
                if (mem_byte_s[k]) begin
                    mem[k][mem_ad[k][9:2]][8*mem_ad[k][1:0] +: 8] <= mem_di[k][7:0];
                end else begin
                    mem[k][mem_ad[k][9:2]] <= mem_di[k];
                end
            end
        end
    end

    // Memory: combinational read, byte read extracts the addressed lane.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mem_do[k] = mem[k][mem_ad[k][9:2]];
            if (mem_byte_l[k]) begin
                mem_do[k] = (mem[k][mem_ad[k][9:2]] >> {mem_ad[k][1:0], 3'b000}) & 32'h0000_00FF;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int p, input logic w, input logic b,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0[i] = 1'b1; we0[i] = w; byte0[i] = b; ad0[i] = a; di0[i] = d;
        end else begin
            req1[i] = 1'b1; we1[i] = w; byte1[i] = b; ad1[i] = a; di1[i] = d;
        end
    endtask

    task automatic clr(input int i, input int p);
        if (p == 0) req0[i] = 1'b0;
        else        req1[i] = 1'b0;
    endtask

    // Two tie rounds with a lone port-0 read in between so that round-robin
    // has port 0 as "last" when the second tie arrives.
    task automatic tie_rounds(input int i, input logic exp_m1_first);
        set_req(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(i, 1, 1'b0, 1'b0, 32'd4, 32'd0);
        step();
        chk("tie1_gnt0", 32'(gnt0[i]), 32'd1);
        chk("tie1_gnt1", 32'(gnt1[i]), 32'd0);
        clr(i, 0);
        step(); step(); step();
        chk("tie1_late_gnt1", 32'(gnt1[i]), 32'd1);
        clr(i, 1);
        step(); step();
        set_req(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("solo_gnt0", 32'(gnt0[i]), 32'd1);
        clr(i, 0);
        step(); step();
        set_req(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(i, 1, 1'b0, 1'b0, 32'd4, 32'd0);
        step();
        chk("tie2_gnt1", 32'(gnt1[i]), 32'(exp_m1_first));
        chk("tie2_gnt0", 32'(gnt0[i]), 32'(!exp_m1_first));
        if (exp_m1_first) clr(i, 1);
        else              clr(i, 0);
        step(); step(); step();
        chk("tie2_late_gnt0", 32'(gnt0[i]), 32'(exp_m1_first));
        chk("tie2_late_gnt1", 32'(gnt1[i]), 32'(!exp_m1_first));
        clr(i, 0);
        clr(i, 1);
        step(); step();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            req0[k] = 1'b0; we0[k] = 1'b0; byte0[k] = 1'b0; ad0[k] = 32'h0; di0[k] = 32'h0;
            req1[k] = 1'b0; we1[k] = 1'b0; byte1[k] = 1'b0; ad1[k] = 32'h0; di1[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0",   32'(gnt0[0]),   32'd0);
        chk("rst_rv0",    32'(rv0[0]),    32'd0);
        chk("rst_rdata0", rdata0[0],      32'd0);
        chk("rst_mem_ad", mem_ad[0],      32'd0);
        chk("rst_mem_we", 32'(mem_we[0]), 32'd0);
        chk("rst_mem_re", 32'(mem_re[0]), 32'd0);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        step();

        // m0 word write then word read at ad=8
        set_req(0, 0, 1'b1, 1'b0, 32'd8, 32'h7FFF_FFFF);
        step();
        chk("t1_gnt0",      32'(gnt0[0]),       32'd1);
        chk("t1_mem_we",    32'(mem_we[0]),     32'd1);
        chk("t1_mem_ad",    mem_ad[0],          32'd8);
        chk("t1_mem_di",    mem_di[0],          32'h7FFF_FFFF);
        chk("t1_byte_s",    32'(mem_byte_s[0]), 32'd0);
        clr(0, 0);
        step();
        chk("t1_we_gone",   32'(mem_we[0]),     32'd0);
        chk("t1_gnt_gone",  32'(gnt0[0]),       32'd0);
        set_req(0, 0, 1'b0, 1'b0, 32'd8, 32'h0);
        step();
        chk("t1_rd_gnt0",   32'(gnt0[0]),       32'd1);
        chk("t1_mem_re",    32'(mem_re[0]),     32'd1);
        clr(0, 0);
        step();
        chk("t1_rv0",       32'(rv0[0]),        32'd1);
        chk("t1_rdata0",    rdata0[0],          32'h7FFF_FFFF);
        step();
        chk("t1_rv0_gone",  32'(rv0[0]),        32'd0);
        chk("t1_rdata_hold", rdata0[0],         32'h7FFF_FFFF);

        // m0 byte write of 0 to ad=8, then word read
        set_req(0, 0, 1'b1, 1'b1, 32'd8, 32'h0);
        step();
        chk("t2_mem_we",    32'(mem_we[0]),     32'd1);
        chk("t2_byte_s",    32'(mem_byte_s[0]), 32'd1);
        clr(0, 0);
        step();
        set_req(0, 0, 1'b0, 1'b0, 32'd8, 32'h0);
        step();
        clr(0, 0);
        step();
        chk("t2_rv0",       32'(rv0[0]),        32'd1);
        chk("t2_rdata0",    rdata0[0],          32'h7FFF_FF00);
        step();

        // m1 word write to ad=20, then byte read
        set_req(0, 1, 1'b1, 1'b0, 32'd20, 32'hAAAA_AAAA);
        step();
        chk("t3_gnt1",      32'(gnt1[0]),       32'd1);
        chk("t3_gnt0",      32'(gnt0[0]),       32'd0);
        chk("t3_mem_we",    32'(mem_we[0]),     32'd1);
        clr(0, 1);
        step();
        set_req(0, 1, 1'b0, 1'b1, 32'd20, 32'h0);
        step();
        chk("t3_mem_re",    32'(mem_re[0]),     32'd1);
        chk("t3_byte_l",    32'(mem_byte_l[0]), 32'd1);
        clr(0, 1);
        step();
        chk("t3_rv1",       32'(rv1[0]),        32'd1);
        chk("t3_rv0",       32'(rv0[0]),        32'd0);
        chk("t3_rdata1",    rdata1[0],          32'h0000_00AA);
        chk("t3_rdata0_keep", rdata0[0],        32'h7FFF_FF00);
        step();

        // ties: round-robin instance, then fixed-priority instance
        tie_rounds(0, 1'b1);
        tie_rounds(1, 1'b0);

        // illegal requests: misaligned word, address past the top; 1020 is legal
        set_req(0, 0, 1'b0, 1'b0, 32'd6, 32'h0);
        step();
        chk("t5_gnt0",      32'(gnt0[0]),       32'd1);
        chk("t5_err0",      32'(err0[0]),       32'd1);
        chk("t5_re0",       32'(mem_re[0]),     32'd0);
        chk("t5_we0",       32'(mem_we[0]),     32'd0);
        clr(0, 0);
        step();
        chk("t5_err0_gone", 32'(err0[0]),       32'd0);
        chk("t5_no_rv0",    32'(rv0[0]),        32'd0);
        set_req(0, 1, 1'b0, 1'b0, 32'd1024, 32'h0);
        step();
        chk("t5_gnt1",      32'(gnt1[0]),       32'd1);
        chk("t5_err1",      32'(err1[0]),       32'd1);
        chk("t5_re1",       32'(mem_re[0]),     32'd0);
        clr(0, 1);
        step();
        chk("t5_no_rv1",    32'(rv1[0]),        32'd0);
        chk("t5_re_idle",   32'(mem_re[0]),     32'd0);
        set_req(0, 1, 1'b0, 1'b0, 32'd1020, 32'h0);
        step();
        chk("t5_max_err",   32'(err1[0]),       32'd0);
        chk("t5_max_re",    32'(mem_re[0]),     32'd1);
        clr(0, 1);
        step();
        chk("t5_max_rv1",   32'(rv1[0]),        32'd1);
        step();

        // RD_LAT=3 instance: full read, then a read cut short by reset
        set_req(2, 1, 1'b1, 1'b0, 32'd0, 32'h1234_5678);
        step();
        chk("t6_wr_we",     32'(mem_we[2]),     32'd1);
        clr(2, 1);
        step();
        set_req(2, 0, 1'b0, 1'b0, 32'd0, 32'h0);
        step();
        chk("t6_re_c1",     32'(mem_re[2]),     32'd1);
        clr(2, 0);
        step();
        chk("t6_re_c2",     32'(mem_re[2]),     32'd1);
        chk("t6_no_rv_c2",  32'(rv0[2]),        32'd0);
        step();
        chk("t6_re_c3",     32'(mem_re[2]),     32'd1);
        chk("t6_no_rv_c3",  32'(rv0[2]),        32'd0);
        step();
        chk("t6_rv0",       32'(rv0[2]),        32'd1);
        chk("t6_re_off",    32'(mem_re[2]),     32'd0);
        chk("t6_rdata0",    rdata0[2],          32'h1234_5678);
        step();
        set_req(2, 0, 1'b0, 1'b0, 32'd4, 32'h0);
        step();
        clr(2, 0);
        step();
        chk("t6_rwait_ad",  mem_ad[2],          32'd4);
        chk("t6_rwait_re",  32'(mem_re[2]),     32'd1);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("t6_rst_re",    32'(mem_re[2]),     32'd0);
        chk("t6_rst_ad",    mem_ad[2],          32'd0);
        chk("t6_rst_rdata", rdata0[2],          32'd0);
        chk("t6_rst_rv0",   32'(rv0[2]),        32'd0);
        step();
        step();
        rst_n[2] = 1'b1;
        step();
        chk("t6_post_rv0",  32'(rv0[2]),        32'd0);
        step();
        chk("t6_post_rv0b", 32'(rv0[2]),        32'd0);
        set_req(2, 1, 1'b0, 1'b0, 32'd0, 32'h0);
        step();
        chk("t6_m1_gnt",    32'(gnt1[2]),       32'd1);
        clr(2, 1);
        step(); step(); step();
        chk("t6_m1_rv",     32'(rv1[2]),        32'd1);
        chk("t6_m1_rdata",  rdata1[2],          32'h1234_5678);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
